acc_src_sel: RTL and testbench



---
 rtl/acc_src_sel_pkg.sv | 15 +
 rtl/acc_src_sel_wait_timer.sv | 27 ++
 rtl/acc_src_sel.sv | 148 ++++++++++++++
 tb/tb_acc_src_sel.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_src_sel_pkg.sv
// Shared types and constants for the accumulator source selector.
package acc_src_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Fixed channel assignment on the accumulator load path
    localparam int unsigned SRC_DATA_MEMORY = 0;
    localparam int unsigned SRC_EXT         = 1;
    localparam int unsigned SRC_ALU         = 2;

endpackage

// File: rtl/acc_src_sel_wait_timer.sv
// Wait-cycle counter; expired_c flags the enabled cycle in which the count reaches TIMEOUT.
module wait_timer #(
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned TMR_WIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    logic [TMR_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + TMR_WIDTH'(1);
        end
    end

    assign expired_c = enable_i && (cnt_q == TMR_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/acc_src_sel.sv
// Registered, handshaked N-source selector feeding the accumulator register.
module acc_src_sel
    import acc_src_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned SEL_WIDTH  = $clog2(NUM_SRC),
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned TMR_WIDTH  = $clog2(TIMEOUT + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req,
    input  logic [SEL_WIDTH-1:0]          sel,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          sel_err,
    output logic                          timeout
);

    state_e                state_q, state_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  to_q, to_d;

    logic                  acc;
    logic [SEL_WIDTH-1:0]  sel_src;
    logic                  ch_hit;
    logic                  ch_valid;
    logic [DATA_WIDTH-1:0] ch_data;
    logic                  tmr_clr;
    logic                  tmr_en;
    logic                  tmr_expired;

    wait_timer #(
        .TIMEOUT   (TIMEOUT),
        .TMR_WIDTH (TMR_WIDTH)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (tmr_clr),
        .enable_i  (tmr_en),
        .expired_c (tmr_expired)
    );

    always_comb begin
        busy    = (state_q == WAIT) || ((state_q == OUT) && !out_ready);
        acc     = req && !busy;
        sel_src = acc ? sel : sel_q;
    end

    // Channel lookup; an index with no matching channel leaves ch_hit low
    always_comb begin
        ch_hit   = 1'b0;
        ch_valid = 1'b0;
        ch_data  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel_src == SEL_WIDTH'(i)) begin
                ch_hit   = 1'b1;
                ch_valid = src_valid[i];
                ch_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        to_d    = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            IDLE, OUT: begin
                if ((state_q == OUT) && out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
                if (acc) begin
                    sel_d   = sel;
                    tmr_clr = 1'b1;
                    if (!ch_hit) begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end else if (ch_valid) begin
                        data_d  = ch_data;
                        valid_d = 1'b1;
                        state_d = OUT;
                    end else begin
                        valid_d = 1'b0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Capture takes priority over an expiring wait
                if (ch_valid) begin
                    data_d  = ch_data;
                    valid_d = 1'b1;
                    state_d = OUT;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        to_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign sel_err   = err_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_acc_src_sel.sv
// Bench for acc_src_sel: transaction-level reference model, directed pins, randomized traffic.
module tb_acc_src_sel;

    localparam int unsigned DW = 11;
    localparam int unsigned NS = 3;
    localparam int unsigned SW = 2;
    localparam int unsigned TO = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic [SW-1:0]     sel;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_valid;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              sel_err;
    logic              timeout;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    acc_src_sel #(
        .DATA_WIDTH (DW),
        .NUM_SRC    (NS),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .sel       (sel),
        .src_data  (src_data),
        .src_valid (src_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .sel_err   (sel_err),
        .timeout   (timeout)
    );

    // Reference model: one outstanding request, its waited cycles, and the held result
    bit            m_pend;
    int            m_psel;
    int            m_waited;
    bit            m_have;
    logic [DW-1:0] m_data;
    bit            m_err;
    bit            m_to;
    bit            m_acc;
    int            m_s;

    function automatic logic [DW-1:0] chan(input int i);
        return src_data[i*DW +: DW];
    endfunction

    function automatic bit model_busy();
        return m_pend || (m_have && !out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_psel = 0; m_waited = 0;
            m_have = 0; m_data = '0; m_err = 0; m_to = 0;
        end else begin
            m_acc = req && !model_busy();
            m_err = 0;
            m_to  = 0;
            if (m_pend) begin
                if (src_valid[m_psel]) begin
                    m_data = chan(m_psel);
                    m_have = 1;
                    m_pend = 0;
                end else begin
                    m_waited = m_waited + 1;
                    if (m_waited == int'(TO)) begin
                        m_to   = 1;
                        m_pend = 0;
                    end
                end
            end else begin
                if (m_have && out_ready) m_have = 0;
                if (m_acc) begin
                    m_s = int'(sel);
                    if (m_s >= int'(NS)) begin
                        m_err = 1;
                    end else if (src_valid[m_s]) begin
                        m_data = chan(m_s);
                        m_have = 1;
                    end else begin
                        m_pend   = 1;
                        m_psel   = m_s;
                        m_waited = 0;
                    end
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            cmp("out_valid", 32'(out_valid), 32'(m_have));
            cmp("out_data",  32'(out_data),  32'(m_data));
            cmp("sel_err",   32'(sel_err),   32'(m_err));
            cmp("timeout",   32'(timeout),   32'(m_to));
            cmp("busy",      32'(busy),      32'(model_busy()));
        end
    end

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        cmp(name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [DW-1:0] v);
        src_data[c*DW +: DW] = v;
    endtask

    int vprob;

    initial begin
        rst_n = 0; req = 0; sel = '0; src_data = '0; src_valid = '0; out_ready = 0;
        tick(); tick();
        chk_en = 1;
        pin("rst_data", 32'(out_data), 32'h0);
        pin("rst_valid", 32'(out_valid), 32'h0);
        pin("rst_busy", 32'(busy), 32'h0);
        pin("rst_err", 32'(sel_err), 32'h0);
        rst_n = 1;
        tick();

        // Immediate capture from the ALU channel, held until consumed
        set_ch(2, 11'h155); src_valid = 3'b100; sel = 2'd2; req = 1; out_ready = 0;
        tick();
        pin("t1_data", 32'(out_data), 32'h155);
        pin("t1_valid", 32'(out_valid), 32'h1);
        pin("t1_busy", 32'(busy), 32'h1);
        tick();
        pin("t1_hold_data", 32'(out_data), 32'h155);
        pin("t1_hold_valid", 32'(out_valid), 32'h1);
        out_ready = 1; req = 0; src_valid = '0;
        tick();
        pin("t1_consumed", 32'(out_valid), 32'h0);

        // Timeout on a source that never becomes valid; sel and other channels ignored while waiting
        req = 1; sel = 2'd0; src_valid = '0;
        tick();
        req = 0; sel = 2'd2; src_valid = 3'b100;
        repeat (14) tick();
        pin("t3_pre_timeout", 32'(timeout), 32'h0);
        pin("t3_pre_busy", 32'(busy), 32'h1);
        tick();
        pin("t3_timeout", 32'(timeout), 32'h1);
        pin("t3_keep_data", 32'(out_data), 32'h155);
        pin("t3_no_valid", 32'(out_valid), 32'h0);
        pin("t3_not_busy", 32'(busy), 32'h0);
        tick();
        pin("t3_pulse_end", 32'(timeout), 32'h0);

        // Data memory becomes valid three cycles after the request
        src_valid = '0; req = 1; sel = 2'd0;
        tick();
        req = 0;
        tick(); tick();
        pin("t2_waiting", 32'(out_valid), 32'h0);
        set_ch(0, 11'h07F); src_valid = 3'b001;
        tick();
        pin("t2_valid", 32'(out_valid), 32'h1);
        pin("t2_data", 32'(out_data), 32'h07F);
        src_valid = '0;
        tick();
        pin("t2_consumed", 32'(out_valid), 32'h0);

        // Illegal select
        req = 1; sel = 2'd3; src_valid = 3'b111;
        tick();
        pin("t4_err", 32'(sel_err), 32'h1);
        pin("t4_no_valid", 32'(out_valid), 32'h0);
        pin("t4_keep_data", 32'(out_data), 32'h07F);
        req = 0;
        tick();
        pin("t4_err_end", 32'(sel_err), 32'h0);

        // Back-to-back alternating transfers
        set_ch(1, 11'h2A1); set_ch(2, 11'h3C4); src_valid = 3'b110; out_ready = 1; req = 1;
        for (int i = 0; i < 8; i++) begin
            sel = (i % 2 == 1) ? 2'd2 : 2'd1;
            tick();
            pin("t5_data", 32'(out_data), (i % 2 == 1) ? 32'h3C4 : 32'h2A1);
            pin("t5_valid", 32'(out_valid), 32'h1);
        end
        req = 0;
        tick();

        // Reset while waiting
        req = 1; sel = 2'd1; src_valid = '0;
        tick();
        req = 0;
        tick();
        pin("t6_wait_busy", 32'(busy), 32'h1);
        rst_n = 0;
        #1;
        pin("t6_rst_valid", 32'(out_valid), 32'h0);
        pin("t6_rst_data", 32'(out_data), 32'h0);
        tick();
        rst_n = 1;
        tick();

        // Reset while holding a result, then a normal request
        req = 1; sel = 2'd2; src_valid = 3'b100; out_ready = 0;
        tick();
        pin("t6_out_data", 32'(out_data), 32'h3C4);
        req = 0;
        rst_n = 0;
        #1;
        pin("t6_rst2_valid", 32'(out_valid), 32'h0);
        pin("t6_rst2_data", 32'(out_data), 32'h0);
        tick();
        rst_n = 1;
        tick();
        req = 1;
        tick();
        pin("t6_after_valid", 32'(out_valid), 32'h1);
        pin("t6_after_data", 32'(out_data), 32'h3C4);

        // Randomized traffic with varying source availability
        vprob = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(3, 0))
                    0: vprob = 0;
                    1: vprob = 10;
                    2: vprob = 60;
                    default: vprob = 100;
                endcase
            end
            req       = ($urandom_range(2, 0) != 0);
            sel       = SW'($urandom_range(3, 0));
            out_ready = ($urandom_range(3, 0) != 0);
            src_data  = (NS*DW)'({$urandom(), $urandom()});
            for (int s = 0; s < int'(NS); s++)
                src_valid[s] = ($urandom_range(99, 0) < vprob);
            if ($urandom_range(599, 0) == 0) begin
                rst_n = 0;
                tick();
                rst_n = 1;
            end
            tick();
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
